// File: rtl/pcihellocore_button_pkg.sv
// Shared register map and edge-type encodings for the pcihellocore push-button controller.
package pcihellocore_button_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // True when a debounced transition to new_val counts as an edge of the selected type.
  function automatic logic edge_hit(input int edge_type, input logic new_val);
    case (edge_type)
      EDGE_RISE: edge_hit = new_val;
      EDGE_FALL: edge_hit = !new_val;
      default:   edge_hit = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pcihellocore_button_debounce.sv
// One-bit synchroniser plus debouncer; chg pulses combinationally on the clock where stable takes new_val.
module pcihellocore_button_debounce
  import pcihellocore_button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable,
  output logic chg,
  output logic new_val
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic meta;
  logic sync_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta   <= pin;
      sync_q <= meta;
    end
  end

  assign new_val = sync_q;
  assign chg     = (sync_q != stable) && (cnt == CNT_LAST);

  // Any return to the accepted level restarts the window, so short glitches never land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_q == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_q;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pcihellocore_button_irq_ctrl.sv
// Avalon-MM button port: debounced data, irq mask and W1C edge-capture registers with a level irq.
module pcihellocore_button_irq_ctrl
  import pcihellocore_button_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [31:0]      rd_word;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pcihellocore_button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (in_port[i]),
      .stable (stable[i]),
      .chg    (chg[i]),
      .new_val(new_val[i])
    );
  end

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_set = '0;
    edge_clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_set[i] = chg[i] & edge_hit(EDGE_TYPE, new_val[i]);
    end
    if (wr && address == ADDR_EDGE) begin
      edge_clr = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_addr_e'(address))
      ADDR_DATA: rd_word = 32'(stable);
      ADDR_MASK: rd_word = 32'(irqmask);
      ADDR_EDGE: rd_word = 32'(edgecapture);
      default:   rd_word = '0;
    endcase
  end

  // A new edge is OR-ed in after the clear so a colliding W1C cannot lose it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
      readdata    <= '0;
    end else begin
      if (wr && address == ADDR_MASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      edgecapture <= (edgecapture & ~edge_clr) | edge_set;
      readdata    <= rd_word;
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule
